// File: rtl/rr_stream_mux.sv
// N-channel to 1 stream multiplexer: fixed-priority or round-robin arbiter feeding a single registered output stage.
// Define RR_STREAM_MUX_BURST_LOCK_EN to add in_last/out_last and lock the grant for the length of a burst.
module rr_stream_mux #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  localparam int CH_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  input  logic [N_CH*DATA_W-1:0] in_data,
`ifdef RR_STREAM_MUX_BURST_LOCK_EN
  input  logic [N_CH-1:0]        in_last,
  output logic                   out_last,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [CH_W-1:0]        out_ch
);

  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] grant_idx;
  logic            grant_vld;
  logic            load_en;
  logic            xfer;
  logic            adv_ptr;
`ifdef RR_STREAM_MUX_BURST_LOCK_EN
  logic            locked;
`endif

  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_CH) sum = sum - N_CH;
    return CH_W'(sum);
  endfunction

  // The last matching assignment wins, so loop order sets the priority of each mode.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    if (!mode) begin
      for (int k = 0; k < N_CH; k++) begin
        if (in_valid[k]) begin
          grant_idx = CH_W'(k);
          grant_vld = 1'b1;
        end
      end
    end else begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (in_valid[wrap_add(rr_ptr, i)]) begin
          grant_idx = wrap_add(rr_ptr, i);
          grant_vld = 1'b1;
        end
      end
    end
`ifdef RR_STREAM_MUX_BURST_LOCK_EN
    // While locked, out_ch still names the bursting channel: no transfer has happened since.
    if (locked) begin
      grant_idx = out_ch;
      grant_vld = in_valid[out_ch];
    end
`endif
  end

  assign load_en = !out_valid || out_ready;
  assign xfer    = rst_n && load_en && grant_vld;

`ifdef RR_STREAM_MUX_BURST_LOCK_EN
  assign adv_ptr = in_last[grant_idx];
`else
  assign adv_ptr = 1'b1;
`endif

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant_idx*DATA_W +: DATA_W];
      out_ch    <= grant_idx;
      if (adv_ptr) rr_ptr <= (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RR_STREAM_MUX_BURST_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked   <= 1'b0;
      out_last <= 1'b0;
    end else if (xfer) begin
      locked   <= !in_last[grant_idx];
      out_last <= in_last[grant_idx];
    end
  end
`endif

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench for rr_stream_mux: directed vector table, hand sequences and randomized traffic vs a reference model.
`timescale 1ns/1ps
module tb_rr_stream_mux;

  localparam int N_CH   = 4;
  localparam int DATA_W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode = 1'b0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
`ifdef RR_STREAM_MUX_BURST_LOCK_EN
  logic [3:0]  in_last = 4'hF;
  logic        out_last;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        mode;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        out_ready;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic [1:0]  exp_ch;
    logic        exp_last;
    logic        chk_last;
  } vec_t;

  typedef struct {
    logic [3:0] ready;
    logic       valid;
    logic [7:0] data;
    logic [1:0] ch;
    int         ptr;
  } pred_t;

  // Reference model state: what the output register should hold and where round-robin resumes.
  logic       m_valid;
  logic [7:0] m_data;
  logic [1:0] m_ch;
  int         m_ptr;

  rr_stream_mux #(.N_CH(N_CH), .DATA_W(DATA_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mode(mode),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
`ifdef RR_STREAM_MUX_BURST_LOCK_EN
    .in_last(in_last),
    .out_last(out_last),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_ch(out_ch)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    m_valid = 1'b0;
    m_data  = '0;
    m_ch    = '0;
    m_ptr   = 0;
  endtask

  function automatic pred_t predict(input logic md, input logic [3:0] v, input logic [31:0] d, input logic ordy);
    pred_t p;
    int    g;
    int    k;
    g = -1;
    if (md == 1'b0) begin
      for (int i = N_CH - 1; i >= 0; i--)
        if (g < 0 && v[i]) g = i;
    end else begin
      for (int j = 0; j < N_CH; j++) begin
        k = (m_ptr + j) % N_CH;
        if (g < 0 && v[k]) g = k;
      end
    end
    p.ready = '0;
    p.valid = m_valid;
    p.data  = m_data;
    p.ch    = m_ch;
    p.ptr   = m_ptr;
    if ((!m_valid || ordy) && g >= 0) begin
      p.ready[g] = 1'b1;
      p.valid    = 1'b1;
      p.data     = d[g*8 +: 8];
      p.ch       = 2'(g);
      p.ptr      = (g + 1) % N_CH;
    end else if (ordy) begin
      p.valid = 1'b0;
    end
    return p;
  endfunction

  function automatic vec_t mk(input logic md, input logic [3:0] v, input logic [31:0] d, input logic ordy,
                              input logic [3:0] er, input logic ev, input logic [7:0] ed, input logic [1:0] ec);
    vec_t r;
    r.mode = md; r.valid = v; r.last = 4'hF; r.data = d; r.out_ready = ordy;
    r.exp_ready = er; r.exp_valid = ev; r.exp_data = ed; r.exp_ch = ec;
    r.exp_last = 1'b1; r.chk_last = 1'b0;
    return r;
  endfunction

  function automatic vec_t fromModel(input logic md, input logic [3:0] v, input logic [31:0] d, input logic ordy);
    pred_t p;
    p = predict(md, v, d, ordy);
    return mk(md, v, d, ordy, p.ready, p.valid, p.data, p.ch);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one beat at the falling edge, check in_ready before the rising edge, registers just after it.
  task automatic applyStimulus(input vec_t v);
    pred_t p;
    @(negedge clk);
    mode      = v.mode;
    in_valid  = v.valid;
    in_data   = v.data;
    out_ready = v.out_ready;
`ifdef RR_STREAM_MUX_BURST_LOCK_EN
    in_last   = v.last;
`endif
    p = predict(v.mode, v.valid, v.data, v.out_ready);
    #1;
    checkOutput("in_ready", 32'(in_ready), 32'(v.exp_ready));
    @(posedge clk);
    #1;
    checkOutput("out_valid", 32'(out_valid), 32'(v.exp_valid));
    checkOutput("out_data", 32'(out_data), 32'(v.exp_data));
    checkOutput("out_ch", 32'(out_ch), 32'(v.exp_ch));
`ifdef RR_STREAM_MUX_BURST_LOCK_EN
    if (v.chk_last) checkOutput("out_last", 32'(out_last), 32'(v.exp_last));
`endif
    m_valid = p.valid;
    m_data  = p.data;
    m_ch    = p.ch;
    m_ptr   = p.ptr;
  endtask

  localparam logic [31:0] D = 32'h44332211;

  initial begin
    vec_t tbl[13];
    vec_t bp;
    vec_t bst[4];

    tbl[0]  = mk(1'b0, 4'b1011, D, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3);
    tbl[1]  = mk(1'b1, 4'b1111, D, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
    tbl[2]  = mk(1'b1, 4'b1111, D, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1);
    tbl[3]  = mk(1'b1, 4'b1111, D, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2);
    tbl[4]  = mk(1'b1, 4'b1111, D, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3);
    tbl[5]  = mk(1'b1, 4'b0001, D, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd3);
    tbl[6]  = mk(1'b1, 4'b0001, D, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
    tbl[7]  = mk(1'b1, 4'b0000, D, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0);
    tbl[8]  = mk(1'b1, 4'b0000, D, 1'b0, 4'b0000, 1'b0, 8'h11, 2'd0);
    tbl[9]  = mk(1'b1, 4'b0100, D, 1'b0, 4'b0100, 1'b1, 8'h33, 2'd2);
    tbl[10] = mk(1'b1, 4'b0001, D, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0);
    tbl[11] = mk(1'b1, 4'b1001, D, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3);
    tbl[12] = mk(1'b0, 4'b0011, D, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1);

    // Reset with every channel requesting: nothing may be acknowledged.
    modelReset();
    rst_n = 1'b0;
    in_valid = 4'hF;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_data", 32'(out_data), 32'd0);
      checkOutput("rst_out_ch", 32'(out_ch), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = '0;

    for (int i = 0; i < 13; i++) applyStimulus(tbl[i]);

    // Back-pressure: 0x55 from ch2 held for five stalled cycles, then drained and refilled on one edge.
    applyStimulus(mk(1'b0, 4'b0100, 32'h00550066, 1'b1, 4'b0100, 1'b1, 8'h55, 2'd2));
    bp = mk(1'b0, 4'b0001, 32'h00550066, 1'b0, 4'b0000, 1'b1, 8'h55, 2'd2);
    repeat (5) applyStimulus(bp);
    applyStimulus(mk(1'b0, 4'b0001, 32'h00550066, 1'b1, 4'b0001, 1'b1, 8'h66, 2'd0));

    for (int i = 0; i < 400; i++) begin
      applyStimulus(fromModel(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                              $urandom, 1'($urandom_range(0, 3) != 0)));
    end

    // Reset asserted while a beat is held must clear it asynchronously.
    applyStimulus(fromModel(1'b0, 4'b0010, 32'h0000AB00, 1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_out_data", 32'(out_data), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    applyStimulus(mk(1'b1, 4'b0010, 32'h0000AB00, 1'b1, 4'b0010, 1'b1, 8'hAB, 2'd1));

`ifdef RR_STREAM_MUX_BURST_LOCK_EN
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    bst[0] = mk(1'b1, 4'b0010, 32'h00B0A1C0, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1);
    bst[1] = mk(1'b1, 4'b0011, 32'h00B0A2C0, 1'b1, 4'b0010, 1'b1, 8'hA2, 2'd1);
    bst[2] = mk(1'b1, 4'b0111, 32'h00B0A3C0, 1'b1, 4'b0010, 1'b1, 8'hA3, 2'd1);
    bst[3] = mk(1'b1, 4'b0101, 32'h00B0A3C0, 1'b1, 4'b0100, 1'b1, 8'hB0, 2'd2);
    bst[0].last = 4'b0000; bst[0].exp_last = 1'b0;
    bst[1].last = 4'b0001; bst[1].exp_last = 1'b0;
    bst[2].last = 4'b0111; bst[2].exp_last = 1'b1;
    bst[3].last = 4'b0101; bst[3].exp_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bst[i].chk_last = 1'b1;
      applyStimulus(bst[i]);
    end
`else
    bst[0] = tbl[0];
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N-channel to 1 stream multiplexer with a built-in arbiter and a registered output stage. It is the sequential successor to the lab mux/priority-encoder blocks.
- Each input channel presents data with a valid/ready handshake.
- The arbiter selects one requesting channel per beat, using either fixed priority or round-robin.
- The selected beat is captured in a single-entry output register, tagged with its source channel index.
- Sits between multiple producers (e.g. switch/UART sources on Nexys4) and one shared consumer.

Parameters:
- N_CH, 4, number of input channels (2..16).
- DATA_W, 8, data width per channel in bits.
- CH_W, $clog2(N_CH), width of channel index (localparam, derived; not overridable).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
- in_valid  input  N_CH  per-channel request.
- in_ready  output  N_CH  per-channel accept; at most one bit high.
- in_data  input  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts beat.
- out_data  output  DATA_W  registered data.
- out_ch  output  CH_W  index of channel that produced out_data.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
  - in_ready=0 combinationally while rst_n=0.
- load_en = !out_valid || out_ready. The output register accepts a new beat when empty, or when the current beat is drained in the same cycle.
- Arbitration (combinational, evaluated every cycle from the current in_valid):
  - mode=0: grant the highest index k with in_valid[k]=1.
  - mode=1: grant the first k with in_valid[k]=1, searching rr_ptr, rr_ptr+1, ... N_CH-1, 0, ... rr_ptr-1 (modulo N_CH wrap).
- in_ready[g] = load_en && in_valid[g] for granted g only; all other bits 0. No input is ever acknowledged without a grant.
- Transfer on input side happens when in_valid[g] && in_ready[g]. On that edge:
  - out_data <= channel g data.
  - out_ch <= g.
  - out_valid <= 1.
  - rr_ptr <= (g == N_CH-1) ? 0 : g+1.
- rr_ptr updates only on a transfer, in both modes, so that switching mode keeps fairness state.
- Drain without refill (out_ready=1, no in_valid): out_valid <= 0; out_data and out_ch hold their last values.
- Simultaneous drain and refill: out_valid stays 1 and the new beat replaces the old one. Throughput is 1 beat/cycle, with no bubble.
- Back-pressure (out_valid=1, out_ready=0): all in_ready=0 and the output register holds stable. Producers must hold in_valid/in_data stable until accepted.
- Latency: 1 cycle from input acceptance to out_valid.
- mode changes take effect on the next arbitration. mode must not change while a channel is mid-burst (see Optional Feature).
- A reset asserted mid-transfer discards the held beat immediately; out_valid=0 with no glitch to 1.
- No in_valid bits set: no grant, in_ready all 0, rr_ptr unchanged.

Optional Feature:
- Macro: RR_STREAM_MUX_BURST_LOCK_EN.
- Defined:
  - Adds ports in_last (input, N_CH) and out_last (output, 1; reset 0; registered alongside out_data).
  - After a transfer from channel g with in_last[g]=0, the grant is locked to g. Other requests are ignored until a transfer from g with in_last[g]=1 completes.
  - rr_ptr advances only on the last beat.
  - An internal locked flag resets to 0.
- Undefined: ports in_last and out_last are absent, and arbitration happens independently on every beat.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, all in_valid=0 -> out_valid=0, out_data=0x00, out_ch=0, in_ready=4'b0000.
- Fixed priority: mode=0, in_valid=4'b1011, in_data ch0=0x11, ch1=0x22, ch3=0x44, out_ready=1 -> in_ready=4'b1000; next cycle out_data=0x44, out_ch=3.
- Round-robin fairness: mode=1, in_valid=4'b1111 held, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with out_valid=1 every cycle after the first.
- Back-pressure: beat 0x55 from ch2 held, out_ready=0 for 5 cycles with ch0 valid -> out_data stays 0x55, in_ready=0000. Raise out_ready -> same edge loads ch0 beat, no bubble.
- Wrap-around: mode=1, rr_ptr=3 (last grant ch2), in_valid=4'b0001 -> grant ch0, rr_ptr becomes 1.
- Burst lock (RR_STREAM_MUX_BURST_LOCK_EN): mode=1, ch1 sends 3 beats (last on third) while ch2 valid -> out_ch=1,1,1 then 2. out_last=1 only on the third beat.
